router_term_monitor: RTL
========================

# router_term_monitor

Synthesizable, parametrised per-terminal delivery monitor for the mesh router's output side. It watches every terminal's `pndng`/`pop`/`data_out` handshake, counts stall cycles against a configurable timeout, checks destination correctness with optional broadcast acceptance, and flags pops with no pending packet. Results are reported through sticky per-terminal flags, a saturating error counter, first-error capture and a worst-case latency register. It sits beside the DUT in the testbench and may also be instantiated in emulation builds, where the SVA checker cannot run.

## Interface
- `ROWS`, 4, mesh rows
- `COLUMS`, 4, mesh columns
- `PCK_SZ`, 40, packet width in bits
- `N_TERMS`, 2*ROWS+2*COLUMS, terminal count
- `DST_MSB`, 31, destination field MSB
- `DST_LSB`, 26, destination field LSB; DST_W = DST_MSB-DST_LSB+1
- `TIMEOUT`, 128, maximum stall cycles allowed, ≥2
- `BCAST_EN`, 0, 1 = a destination equal to BCAST_ID is legal on every terminal
- `BCAST_ID`, all-ones of DST_W, broadcast destination code
- `ERR_W`, 16, error counter width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `data_out`  in  PCK_SZ × N_TERMS  packet presented by each terminal
- `pndng`  in  1 × N_TERMS  packet pending on the terminal
- `pop`  in  1 × N_TERMS  consumer pops the terminal
- `enable`  in  1  monitoring active
- `clear_counts`  in  1  synchronous clear of reported results
- `timeout_flag`  out  N_TERMS  sticky, per terminal
- `dst_flag`  out  N_TERMS  sticky, per terminal
- `spur_flag`  out  N_TERMS  sticky, per terminal
- `err_count`  out  ERR_W  total events, saturating
- `first_err_valid`  out  1  first error has been captured
- `first_err_term`  out  $clog2(N_TERMS)  terminal of the first error
- `first_err_kind`  out  2  01 timeout, 10 destination, 11 spurious pop
- `wait_max`  out  $clog2(TIMEOUT+2)  worst delivery latency observed

## Operation
- Accept on terminal i: `pndng[i] & pop[i]`.
- Stall on terminal i: `pndng[i] & ~pop[i]`.
- Per-terminal `wait_cnt[i]`:
  - Increments on a stall and saturates at TIMEOUT.
  - Returns to 0 on an accept or when `pndng[i]` is low.
- Timeout event: a stall while `wait_cnt[i] == TIMEOUT-1`, i.e. the counter is stepping to TIMEOUT. It fires once per stall episode.
- Destination event: an accept where the destination field is not equal to i, and the packet is not a legal broadcast (`BCAST_EN` with destination equal to `BCAST_ID`).
- Spurious event: `pop[i] & ~pndng[i]`.
- The three event kinds are mutually exclusive per terminal per cycle.
- Each event sets the matching sticky flag bit.
- `err_count` adds the number of events across all terminals in the cycle and saturates at 2^ERR_W-1.
- First-error capture:
  - Only happens while `first_err_valid` is 0.
  - Captures the lowest-index terminal with an event in that cycle, together with its kind.
  - Then sets `first_err_valid`.
- Delivery latency on an accept is `wait_cnt[i]+1`. `wait_max` keeps the maximum seen, saturating at TIMEOUT+1.
- `enable` low:
  - No events, no `wait_max` update.
  - All `wait_cnt` held at 0.
  - Outputs hold their values.
- `clear_counts`:
  - Zeroes flags, `err_count`, `first_err_*` and `wait_max`.
  - Does not touch `wait_cnt`.
  - Events in the same cycle are dropped (clear wins).

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N, i.e. 1 cycle of latency.
- Reset, asserted at any time including mid-stall: every output and every `wait_cnt` goes to 0 at the next edge. Reset overrides `clear_counts` and `enable`.
- Timeout boundary:
  - A pop on stall cycle TIMEOUT (`wait_cnt == TIMEOUT-1`, accept) gives no timeout, with latency TIMEOUT.
  - Stall in that cycle gives a timeout.
- After a timeout with `pndng` still high, a late accept records latency TIMEOUT+1 and checks the destination normally.
- `err_count` saturation: it holds at max when multiple simultaneous events would overflow.
- First error against `clear_counts`: the first error after a clear is captured afresh.

## Test plan
- Defaults: terminal 3, `pndng` high with destination 3, pop after 5 stall cycles -> no flags, `err_count` 0, `wait_max` 6.
- Terminal 7, `pndng` held 128 cycles with no pop -> `timeout_flag[7]` 1 after the 128th stall cycle; `err_count` 1; `first_err_term` 7, kind 01. Held 50 more cycles -> `err_count` stays 1. Pop on stall cycle 128 in a separate run -> no timeout, `wait_max` 128.
- Terminal 2 accepts destination 5 -> `dst_flag[2]`, kind 10. With `BCAST_EN`=1, terminal 2 accepting destination 6'h3F -> no error.
- Same cycle: spurious pop on terminal 9 and bad destination on terminal 4 -> `err_count` +2; `first_err_term` 4, kind 10; `spur_flag[9]` 1.
- ERR_W=2: five spurious pops -> `err_count` 3. Then `clear_counts` plus one event in the same cycle -> all zero. Next event -> `err_count` 1, first error re-captured.
- Reset asserted on stall cycle 100 of a stall -> all outputs 0. Stall continues 127 more cycles -> no timeout; cycle 128 -> timeout.

Source files
------------

// File: rtl/router_term_monitor.sv
// Per-terminal delivery monitor for the mesh router outputs: stall timeout, destination
// check, spurious-pop detection, sticky flags, saturating error count and worst latency.
module router_term_monitor #(
    parameter int                         ROWS     = 4,
    parameter int                         COLUMS   = 4,
    parameter int                         PCK_SZ   = 40,
    parameter int                         N_TERMS  = 2*ROWS + 2*COLUMS,
    parameter int                         DST_MSB  = 31,
    parameter int                         DST_LSB  = 26,
    parameter int                         TIMEOUT  = 128,
    parameter int                         BCAST_EN = 0,
    parameter logic [DST_MSB-DST_LSB:0]   BCAST_ID = '1,
    parameter int                         ERR_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PCK_SZ-1:0]             data_out [N_TERMS],
    input  logic [N_TERMS-1:0]            pndng,
    input  logic [N_TERMS-1:0]            pop,
    input  logic                          enable,
    input  logic                          clear_counts,
    output logic [N_TERMS-1:0]            timeout_flag,
    output logic [N_TERMS-1:0]            dst_flag,
    output logic [N_TERMS-1:0]            spur_flag,
    output logic [ERR_W-1:0]              err_count,
    output logic                          first_err_valid,
    output logic [$clog2(N_TERMS)-1:0]    first_err_term,
    output logic [1:0]                    first_err_kind,
    output logic [$clog2(TIMEOUT+2)-1:0]  wait_max
);

    localparam int DST_W  = DST_MSB - DST_LSB + 1;
    localparam int WM_W   = $clog2(TIMEOUT + 2);
    localparam int TERM_W = $clog2(N_TERMS);
    localparam int CNT_W  = $clog2(N_TERMS + 1);
    localparam int SUM_W  = ERR_W + CNT_W;

    localparam logic [WM_W-1:0] TMO_V   = WM_W'(TIMEOUT);
    localparam logic [WM_W-1:0] TMO_PRE = WM_W'(TIMEOUT - 1);
    localparam logic [WM_W-1:0] LAT_LIM = WM_W'(TIMEOUT + 1);

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'({ERR_W{1'b1}}))
            return '1;
        return sum[ERR_W-1:0];
    endfunction

    function automatic logic [WM_W-1:0] sat_inc(input logic [WM_W-1:0] v,
                                                input logic [WM_W-1:0] lim);
        return (v >= lim) ? lim : v + WM_W'(1);
    endfunction

    logic [WM_W-1:0]    wait_cnt [N_TERMS];
    logic [N_TERMS-1:0] ev_tmo, ev_dst, ev_spur, ev_vec;
    logic [CNT_W-1:0]   ev_num;
    logic [WM_W-1:0]    lat_max, lat_i;
    logic [DST_W-1:0]   dst_i;
    logic [TERM_W-1:0]  fe_term;
    logic [1:0]         fe_kind;
    logic               unused_data;

    // Stage 0: classify this cycle's handshakes into events and latencies
    always_comb begin
        ev_tmo      = '0;
        ev_dst      = '0;
        ev_spur     = '0;
        lat_max     = '0;
        lat_i       = '0;
        dst_i       = '0;
        unused_data = 1'b0;
        for (int i = 0; i < N_TERMS; i++) begin
            unused_data = unused_data ^ (^data_out[i]);
            dst_i       = data_out[i][DST_MSB:DST_LSB];
            lat_i       = sat_inc(wait_cnt[i], LAT_LIM);
            ev_tmo[i]   = enable & pndng[i] & ~pop[i] & (wait_cnt[i] == TMO_PRE);
            ev_dst[i]   = enable & pndng[i] & pop[i] & (dst_i != DST_W'(i))
                        & ~((BCAST_EN != 0) & (dst_i == BCAST_ID));
            ev_spur[i]  = enable & pop[i] & ~pndng[i];
            if (enable && pndng[i] && pop[i] && (lat_i > lat_max))
                lat_max = lat_i;
        end
    end

    assign ev_vec = ev_tmo | ev_dst | ev_spur;
    assign ev_num = CNT_W'($countones(ev_vec));

    // Descending scan so the lowest-index terminal is the one left standing
    always_comb begin
        fe_term = '0;
        fe_kind = 2'b00;
        for (int i = N_TERMS - 1; i >= 0; i--) begin
            if (ev_vec[i]) begin
                fe_term = TERM_W'(i);
                fe_kind = ev_tmo[i] ? 2'b01 : (ev_dst[i] ? 2'b10 : 2'b11);
            end
        end
    end

    // Stage 1: stall counters, unaffected by clear_counts
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TERMS; i++) begin
            if (reset || !enable)
                wait_cnt[i] <= '0;
            else if (pndng[i] && !pop[i])
                wait_cnt[i] <= sat_inc(wait_cnt[i], TMO_V);
            else
                wait_cnt[i] <= '0;
        end
    end

    // Stage 1: reported results
    always_ff @(posedge clk) begin
        if (reset || clear_counts) begin
            timeout_flag    <= '0;
            dst_flag        <= '0;
            spur_flag       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_term  <= '0;
            first_err_kind  <= 2'b00;
            wait_max        <= '0;
        end else begin
            timeout_flag <= timeout_flag | ev_tmo;
            dst_flag     <= dst_flag | ev_dst;
            spur_flag    <= spur_flag | ev_spur;
            err_count    <= sat_add(err_count, ev_num);
            if (!first_err_valid && (ev_vec != '0)) begin
                first_err_valid <= 1'b1;
                first_err_term  <= fe_term;
                first_err_kind  <= fe_kind;
            end
            if (lat_max > wait_max)
                wait_max <= lat_max;
        end
    end

endmodule
